// File: rtl/banked_regfile_v2_if.sv
// Port bundle of the banked register file: write/read ports, bank select and clear engine.
interface banked_regfile_v2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 5,
  parameter int BANK_WIDTH = 6
);
  logic [BANK_WIDTH-1:0]   bankSelect_i;
  logic [3:0]              wrEn_i;
  logic [4*IDX_WIDTH-1:0]  wrIdx_i;
  logic [4*DATA_WIDTH-1:0] wrData_i;
  logic [3:0]              rdEn_i;
  logic [4*DATA_WIDTH-1:0] rdAddr_i;
  logic [4*DATA_WIDTH-1:0] rdData_o;
  logic                    bankErr_o;
  logic                    clearReq_i;
  logic [BANK_WIDTH-1:0]   clearBank_i;
  logic                    clearBusy_o;
  logic                    clearDone_o;

  modport master (
    output bankSelect_i, wrEn_i, wrIdx_i, wrData_i, rdEn_i, rdAddr_i, clearReq_i, clearBank_i,
    input  rdData_o, bankErr_o, clearBusy_o, clearDone_o
  );

  modport slave (
    input  bankSelect_i, wrEn_i, wrIdx_i, wrData_i, rdEn_i, rdAddr_i, clearReq_i, clearBank_i,
    output rdData_o, bankErr_o, clearBusy_o, clearDone_o
  );
endinterface

// File: rtl/banked_regfile_v2.sv
// Parametrised banked register file: 4 write ports, 4 read ports with immediate passthrough,
// write-first bypass, range protection and a multi-cycle bank-clear engine.
module banked_regfile_v2 #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGS_PER_BANK = 32,
  parameter int IDX_WIDTH     = 5,
  parameter int NUM_BANKS     = 4,
  parameter int BANK_WIDTH    = 6
) (
  input logic               clock_i,
  input logic               reset_i,
  banked_regfile_v2_if.slave rf
);

  localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ISEL_W = (REGS_PER_BANK > 1) ? $clog2(REGS_PER_BANK) : 1;
  localparam logic [BANK_WIDTH:0] NB_L   = (BANK_WIDTH+1)'(NUM_BANKS);
  localparam logic [IDX_WIDTH:0]  REGS_L = (IDX_WIDTH+1)'(REGS_PER_BANK);
  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(REGS_PER_BANK - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_WIDTH-1:0]     k_q;
  logic [BANK_WIDTH-1:0]    clr_bank_q;
  logic [DATA_WIDTH-1:0]    mem [NUM_BANKS][REGS_PER_BANK];
  logic [4*DATA_WIDTH-1:0]  rd_q;
  logic                     bank_err_q;

  logic                     bank_ok, clr_bank_ok, clr_we, clr_accept, bank_err_d;
  logic [BSEL_W-1:0]        bank_s, clr_s;
  logic [3:0]               wr_ok;
  logic [IDX_WIDTH-1:0]     widx [4];
  logic [DATA_WIDTH-1:0]    wdat [4];
  logic [IDX_WIDTH-1:0]     ridx [4];
  logic [DATA_WIDTH-1:0]    rd_d [4];

  always_comb begin
    bank_ok     = ({1'b0, rf.bankSelect_i} < NB_L);
    clr_bank_ok = ({1'b0, rf.clearBank_i} < NB_L);
    bank_s      = rf.bankSelect_i[BSEL_W-1:0];
    clr_s       = clr_bank_q[BSEL_W-1:0];
    clr_we      = (state_q == CLEAR);
    clr_accept  = (state_q == IDLE) && rf.clearReq_i && clr_bank_ok;
    bank_err_d  = (!bank_ok && ((|rf.wrEn_i) || (|rf.rdEn_i))) ||
                  ((state_q == IDLE) && rf.clearReq_i && !clr_bank_ok);
    for (int unsigned p = 0; p < 4; p++) begin
      widx[p]  = rf.wrIdx_i[p*IDX_WIDTH +: IDX_WIDTH];
      wdat[p]  = rf.wrData_i[p*DATA_WIDTH +: DATA_WIDTH];
      ridx[p]  = rf.rdAddr_i[p*DATA_WIDTH +: IDX_WIDTH];
      wr_ok[p] = rf.wrEn_i[p] && bank_ok && ({1'b0, widx[p]} < REGS_L);
    end
  end

  // Bypass applies the clear first, then ports in ascending priority, matching the
  // storage order below so a read returns exactly what the register will hold.
  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      rd_d[p] = '0;
      if (!rf.rdEn_i[p]) begin
        rd_d[p] = rf.rdAddr_i[p*DATA_WIDTH +: DATA_WIDTH];
      end else if (bank_ok && ({1'b0, ridx[p]} < REGS_L)) begin
        rd_d[p] = mem[bank_s][ridx[p][ISEL_W-1:0]];
        if (clr_we && (clr_bank_q == rf.bankSelect_i) && (k_q == ridx[p])) begin
          rd_d[p] = '0;
        end
        for (int unsigned q = 0; q < 4; q++) begin
          if (wr_ok[q] && (widx[q] == ridx[p])) begin
            rd_d[p] = wdat[q];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_accept) state_d = CLEAR;
      CLEAR:   if (k_q == K_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      k_q        <= '0;
      clr_bank_q <= '0;
      rd_q       <= '0;
      bank_err_q <= 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned r = 0; r < REGS_PER_BANK; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      bank_err_q <= bank_err_d;
      if (clr_accept) begin
        clr_bank_q <= rf.clearBank_i;
        k_q        <= '0;
      end else if (clr_we) begin
        k_q <= k_q + 1'b1;
      end
      if (clr_we) begin
        mem[clr_s][k_q[ISEL_W-1:0]] <= '0;
      end
      for (int unsigned p = 0; p < 4; p++) begin
        if (wr_ok[p]) begin
          mem[bank_s][widx[p][ISEL_W-1:0]] <= wdat[p];
        end
        rd_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_d[p];
      end
    end
  end

  assign rf.rdData_o    = rd_q;
  assign rf.bankErr_o   = bank_err_q;
  assign rf.clearBusy_o = (state_q == CLEAR);
  assign rf.clearDone_o = (state_q == DONE);

endmodule

// File: doc/banked_regfile_v2.md
Name: banked_regfile_v2

Overview:
Parametrised successor to the banked 16-bit register file. Width, bank depth and bank count are parameters; the bank select is generalised to any bank count.
It keeps the four writeback ports (two arithmetic, two load/store) and the four read ports (primary and secondary for execution ports A and B), with immediate passthrough.
It adds four things:
- deterministic same-address write priority
- write-to-read bypass
- out-of-range protection
- a multi-cycle bank-clear engine for process/stack-frame allocation.

Parameters:
DATA_WIDTH, 16, register and data-bus width
REGS_PER_BANK, 32, registers per bank (at most 2^IDX_WIDTH)
IDX_WIDTH, 5, register-index width
NUM_BANKS, 4, number of banks
BANK_WIDTH, 6, width of the bank-select bus

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-high reset
bankSelect_i  in  BANK_WIDTH  active bank for all port accesses
wrEn_i  in  4  write enables; bit0 arith A, bit1 arith B, bit2 LS A, bit3 LS B
wrIdx_i  in  4*IDX_WIDTH  write indices, packed in the same order as wrEn_i
wrData_i  in  4*DATA_WIDTH  write data, packed in the same order as wrEn_i
rdEn_i  in  4  read enables; bit0 A primary, bit1 A secondary, bit2 B primary, bit3 B secondary
rdAddr_i  in  4*DATA_WIDTH  read address or immediate; low IDX_WIDTH bits are the register index
rdData_o  out  4*DATA_WIDTH  registered read data, in the same order as rdEn_i
bankErr_o  out  1  one-cycle pulse when an access targets a bank >= NUM_BANKS
clearReq_i  in  1  request to zero one bank
clearBank_i  in  BANK_WIDTH  bank to clear, sampled on request acceptance
clearBusy_o  out  1  high while the clear engine is running
clearDone_o  out  1  one-cycle pulse when a clear completes

Behaviour:
- Reset (synchronous, priority over everything):
  - All registers go to 0; rdData_o, bankErr_o, clearBusy_o and clearDone_o go to 0; the FSM goes to IDLE.
  - Writes and read updates in a reset cycle are ignored.
- Physical address = bankSelect_i*REGS_PER_BANK + idx.
- Reads (1-cycle latency; rdData_o updates on the edge after inputs are sampled):
  - rdEn=1: output the register contents.
  - rdEn=0: output rdAddr_i unchanged (immediate passthrough, full DATA_WIDTH).
- Write-first bypass: if a write in the same cycle hits the same physical register as an enabled read, the read returns the new write data.
- Same-address write conflict: priority is LS B > LS A > arith B > arith A. Only the winner is stored; a bypassed read sees the winner.
- Range checks:
  - idx >= REGS_PER_BANK: the read returns 0 and the write is dropped.
  - bankSelect_i >= NUM_BANKS: all reads return 0 (immediate passthrough is unaffected) and all writes are dropped.
  - bankErr_o pulses the next cycle if any enabled access occurred under an illegal bank.
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clearReq_i=1 with clearBank_i < NUM_BANKS latches the bank, sets counter k=0 and moves to CLEAR. An illegal clearBank_i is ignored and pulses bankErr_o.
  - CLEAR: each cycle zeroes register k of the latched bank, then k++. clearBusy_o=1. After k = REGS_PER_BANK-1 is written, move to DONE.
  - DONE: clearDone_o=1 for exactly one cycle, then IDLE. Total latency from acceptance to done is REGS_PER_BANK+1 cycles.
  - clearReq_i is ignored outside IDLE.
  - A port write to the same register in the same cycle as the clear write wins over the clear.
  - Reads are never stalled. A read of the register being cleared in that cycle returns 0 (bypass applies) unless a port write also targets it.
  - Reset mid-clear aborts the clear: FSM to IDLE, no clearDone_o pulse.
- Bank switching takes effect the same cycle; there are no wait states.

Test Plan:
1. Reset -> all rdData_o=0. bank=1, arith A writes idx3=0x1234. Next cycle read A primary idx3 -> 0x1234. bank=0 idx3 -> 0x0000.
2. Same cycle: arith A writes idx5=0x1111, LS B writes idx5=0x2222, enabled read of idx5 -> rdData=0x2222 (bypass). Following read -> 0x2222.
3. rdEn=0 with rdAddr=0xBEEF -> rdData=0xBEEF. Read idx 30 with REGS_PER_BANK=28 -> 0. bank=5 with NUM_BANKS=4: write dropped, bankErr_o pulses once.
4. Fill bank 2 with 0xFFFF, clearReq bank2 -> clearBusy high for 32 cycles, clearDone pulses at cycle 33. All bank-2 reads -> 0; bank 1 contents unchanged.
5. During a clear of bank 2 at k=10: write idx10=0xAAAA -> value kept. Second clearReq during busy -> ignored, single clearDone.
6. Assert reset at k=7 of a clear -> FSM IDLE, no clearDone_o, all registers 0, clearBusy_o=0 the next cycle.
